// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Purpose  : Shares the single-port data SRAM between the core load/store
//             path and a debug/loader port. The core has priority; a
//             starvation counter forces a debug grant after STARVE_LIMIT
//             consecutive denied debug cycles. A halt handshake
//             (dbg_halt_req / dbg_halt_ack) gives the debug port exclusive
//             ownership of the SRAM.
//  Ports    : clk, rstn                      - clock, async active-low reset
//             core_* (req/we/addr/wmask/wdata -> gnt/rvalid/rdata)
//                                            - core access port
//             dbg_*  (same as core)          - debug access port
//             dbg_halt_req / dbg_halt_ack    - exclusive-ownership handshake
//             mem_en/we/addr/wmask/wdata, mem_rdata
//                                            - SRAM macro interface
//                                              (read latency 1 cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rstn,
    // core port
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W/8-1:0] core_wmask,
    input  logic [DATA_W-1:0]   core_wdata,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    // debug port
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W/8-1:0] dbg_wmask,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_W-1:0]   dbg_rdata,
    // halt handshake
    input  logic                dbg_halt_req,
    output logic                dbg_halt_ack,
    // SRAM interface
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int                CNT_W          = 4;
    localparam logic [CNT_W-1:0]  C_STARVE_LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    state_t           r_state;
    owner_t           r_rdOwner;
    logic [CNT_W-1:0] r_starveCnt;
    logic             r_haltAck;

    logic             w_coreGnt;
    logic             w_dbgGnt;
    owner_t           w_rdOwnerNext;
    logic [CNT_W-1:0] w_starveNext;

    // ------------------------------------------------------------------
    // Grant decision (combinational, same cycle as the request).
    // Grants are forced low while reset is asserted so that no SRAM
    // access can be issued from a port that happens to be requesting.
    // ------------------------------------------------------------------
    always_comb begin
        w_coreGnt = 1'b0;
        w_dbgGnt  = 1'b0;
        case (r_state)
            ST_RUN: begin
                // Debug overrides the core only after it has been denied
                // for STARVE_LIMIT consecutive cycles.
                if (core_req && !(dbg_req && (r_starveCnt == C_STARVE_LIMIT))) begin
                    w_coreGnt = 1'b1;
                end else if (dbg_req) begin
                    w_dbgGnt = 1'b1;
                end
            end
            ST_LOCKED: begin
                w_dbgGnt = dbg_req;
            end
            default: begin
                // DRAIN: SRAM is kept idle while the halt handshake settles.
            end
        endcase
        w_coreGnt = w_coreGnt & rstn;
        w_dbgGnt  = w_dbgGnt  & rstn;
    end

    // Read-return tag for the access granted this cycle.
    always_comb begin
        w_rdOwnerNext = OWN_NONE;
        if (w_coreGnt && !core_we) begin
            w_rdOwnerNext = OWN_CORE;
        end else if (w_dbgGnt && !dbg_we) begin
            w_rdOwnerNext = OWN_DBG;
        end
    end

    // Denied-debug streak, saturating at the limit.
    always_comb begin
        w_starveNext = '0;
        if (dbg_req && !w_dbgGnt) begin
            w_starveNext = (r_starveCnt == C_STARVE_LIMIT) ? r_starveCnt
                                                           : r_starveCnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // SRAM drive: winner's fields, zero when idle so mem_we is never
    // asserted without mem_en.
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = w_coreGnt | w_dbgGnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (w_coreGnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wmask = core_wmask;
            mem_wdata = core_wdata;
        end else if (w_dbgGnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wmask = dbg_wmask;
            mem_wdata = dbg_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Halt state machine, read tag and starvation counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_RUN;
            r_rdOwner   <= OWN_NONE;
            r_starveCnt <= '0;
            r_haltAck   <= 1'b0;
        end else begin
            r_rdOwner <= w_rdOwnerNext;
            case (r_state)
                ST_RUN: begin
                    r_starveCnt <= w_starveNext;
                    if (dbg_halt_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_starveCnt <= w_starveNext;
                    if (!dbg_halt_req) begin
                        r_state <= ST_RUN;
                    end else if (w_rdOwnerNext == OWN_NONE) begin
                        // Any read tagged on entry returns during this
                        // cycle and no new access is granted here, so the
                        // SRAM is quiescent from the next edge on.
                        r_state   <= ST_LOCKED;
                        r_haltAck <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    r_starveCnt <= '0;
                    if (!dbg_halt_req) begin
                        r_state   <= ST_RUN;
                        r_haltAck <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_starveCnt <= '0;
                    r_haltAck   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign core_gnt     = w_coreGnt;
    assign dbg_gnt      = w_dbgGnt;
    assign dbg_halt_ack = r_haltAck;
    assign core_rvalid  = (r_rdOwner == OWN_CORE);
    assign dbg_rvalid   = (r_rdOwner == OWN_DBG);
    assign core_rdata   = core_rvalid ? mem_rdata : '0;
    assign dbg_rdata    = dbg_rvalid  ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Purpose  : Self-checking bench for dmem_port_arbiter. A behavioural SRAM
//             answers the DUT's mem_* port; a monitor keeps a reference
//             memory and per-port expected-read queues filled at grant time
//             and popped on rvalid, and checks arbitration fairness with a
//             denial-streak model. Directed sequences cover reset, priority,
//             starvation, masked writes, halt handshake and reset mid-read.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 32;
    localparam int MASK_W       = DATA_W / 8;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              core_req, core_we, core_gnt, core_rvalid;
    logic [ADDR_W-1:0] core_addr;
    logic [MASK_W-1:0] core_wmask;
    logic [DATA_W-1:0] core_wdata, core_rdata;
    logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [MASK_W-1:0] dbg_wmask;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              dbg_halt_req, dbg_halt_ack;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    bit monEn  = 1'b0;
    bit arbChk = 1'b0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wmask(core_wmask), .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wmask(dbg_wmask), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_halt_req(dbg_halt_req), .dbg_halt_ack(dbg_halt_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] initVal(input int a);
        if (a == 16) return 32'hDEADBEEF;
        if (a == 32) return 32'h12345678;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // ---------------- behavioural SRAM (1-cycle read latency) ----------------
    logic [31:0] sram [0:4095];
    logic [31:0] memRdataQ = '0;
    assign mem_rdata = memRdataQ;

    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = initVal(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) sram[mem_addr] = merge(sram[mem_addr], mem_wdata, mem_wmask);
                else        memRdataQ <= sram[mem_addr];
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] refMem [0:4095];
    logic [31:0] coreQ [$];
    logic [31:0] dbgQ  [$];

    initial begin
        int          waited;
        bit          prevCoreRd, prevDbgRd, expC, expD;
        logic [31:0] e;
        waited = 0; prevCoreRd = 1'b0; prevDbgRd = 1'b0;
        for (int i = 0; i < 4096; i++) refMem[i] = initVal(i);
        forever begin
            @(negedge clk);
            if (!monEn) begin
                coreQ.delete(); dbgQ.delete();
                prevCoreRd = 1'b0; prevDbgRd = 1'b0; waited = 0;
            end else begin
                // read returns: exactly one cycle after a read grant
                chk1("core_rvalid timing", core_rvalid, prevCoreRd);
                chk1("dbg_rvalid timing", dbg_rvalid, prevDbgRd);
                if (prevCoreRd && coreQ.size() > 0) begin
                    e = coreQ.pop_front();
                    if (core_rvalid) chk("core_rdata", core_rdata, e);
                end
                if (prevDbgRd && dbgQ.size() > 0) begin
                    e = dbgQ.pop_front();
                    if (dbg_rvalid) chk("dbg_rdata", dbg_rdata, e);
                end
                if (!core_rvalid) chk("core_rdata idle", core_rdata, 32'h0);
                if (!dbg_rvalid)  chk("dbg_rdata idle", dbg_rdata, 32'h0);

                // SRAM drive invariants
                chk1("single grant", core_gnt & dbg_gnt, 1'b0);
                chk1("mem_en", mem_en, core_gnt | dbg_gnt);
                if (!mem_en) chk1("mem_we idle", mem_we, 1'b0);
                if (core_gnt) begin
                    chk("core mem_addr", 32'(mem_addr), 32'(core_addr));
                    chk1("core mem_we", mem_we, core_we);
                    if (core_we) begin
                        chk("core mem_wdata", mem_wdata, core_wdata);
                        chk("core mem_wmask", 32'(mem_wmask), 32'(core_wmask));
                    end
                end
                if (dbg_gnt) begin
                    chk("dbg mem_addr", 32'(mem_addr), 32'(dbg_addr));
                    chk1("dbg mem_we", mem_we, dbg_we);
                    if (dbg_we) begin
                        chk("dbg mem_wdata", mem_wdata, dbg_wdata);
                        chk("dbg mem_wmask", 32'(mem_wmask), 32'(dbg_wmask));
                    end
                end

                // Arbitration: core first, unless debug has already been
                // turned away STARVE_LIMIT cycles in a row.
                if (arbChk) begin
                    expC = core_req && !(dbg_req && waited >= STARVE_LIMIT);
                    expD = dbg_req && !expC;
                    chk1("arb core_gnt", core_gnt, expC);
                    chk1("arb dbg_gnt", dbg_gnt, expD);
                    waited = (dbg_req && !expD) ? waited + 1 : 0;
                end else begin
                    waited = 0;
                end

                // record the effect of this cycle's access
                prevCoreRd = core_gnt && !core_we;
                prevDbgRd  = dbg_gnt && !dbg_we;
                if (core_gnt) begin
                    if (core_we) refMem[core_addr] = merge(refMem[core_addr], core_wdata, core_wmask);
                    else         coreQ.push_back(refMem[core_addr]);
                end
                if (dbg_gnt) begin
                    if (dbg_we) refMem[dbg_addr] = merge(refMem[dbg_addr], dbg_wdata, dbg_wmask);
                    else        dbgQ.push_back(refMem[dbg_addr]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setCore(input logic r, input logic w, input logic [11:0] a,
                           input logic [3:0] m, input logic [31:0] d);
        core_req = r; core_we = w; core_addr = a; core_wmask = m; core_wdata = d;
    endtask

    task automatic setDbg(input logic r, input logic w, input logic [11:0] a,
                          input logic [3:0] m, input logic [31:0] d);
        dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wmask = m; dbg_wdata = d;
    endtask

    task automatic newCore(input int p, input int amax);
        setCore(int'($urandom_range(99)) < p, 1'($urandom_range(1)),
                12'($urandom_range(amax)), 4'($urandom_range(15)), $urandom);
    endtask

    task automatic newDbg(input int p, input int amax);
        setDbg(int'($urandom_range(99)) < p, 1'($urandom_range(1)),
               12'($urandom_range(amax)), 4'($urandom_range(15)), $urandom);
    endtask

    task automatic randCycles(input int n, input int pC, input int pD, input int amax);
        logic cg, dg;
        step();
        newCore(pC, amax);
        newDbg(pD, amax);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cg = core_gnt;
            dg = dbg_gnt;
            step();
            // a requester keeps its request stable until it is granted
            if (!core_req || cg) newCore(pC, amax);
            if (!dbg_req || dg)  newDbg(pD, amax);
        end
        core_req = 1'b0;
        dbg_req  = 1'b0;
    endtask

    task automatic chkAllIdle(input string tag);
        chk1({tag, " core_gnt"}, core_gnt, 1'b0);
        chk1({tag, " dbg_gnt"}, dbg_gnt, 1'b0);
        chk1({tag, " core_rvalid"}, core_rvalid, 1'b0);
        chk1({tag, " dbg_rvalid"}, dbg_rvalid, 1'b0);
        chk1({tag, " halt_ack"}, dbg_halt_ack, 1'b0);
        chk1({tag, " mem_en"}, mem_en, 1'b0);
        chk1({tag, " mem_we"}, mem_we, 1'b0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, " core_rdata"}, core_rdata, 32'h0);
        chk({tag, " dbg_rdata"}, dbg_rdata, 32'h0);
    endtask

    initial begin
        logic cg, dg;
        // Reset with both ports requesting: nothing may be granted.
        rstn = 1'b0;
        dbg_halt_req = 1'b0;
        setCore(1'b1, 1'b1, 12'h3, 4'hF, 32'h1111_1111);
        setDbg(1'b1, 1'b1, 12'h4, 4'hF, 32'h2222_2222);
        @(negedge clk);
        chkAllIdle("reset");
        step();
        core_req = 1'b0;
        dbg_req  = 1'b0;
        step();
        rstn   = 1'b1;
        monEn  = 1'b1;
        arbChk = 1'b1;

        // Core read of 0x010 (holds 0xDEADBEEF)
        step(); setCore(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        @(negedge clk); chk1("t1 core_gnt", core_gnt, 1'b1);
        step(); core_req = 1'b0;
        @(negedge clk);
        chk1("t1 core_rvalid", core_rvalid, 1'b1);
        chk("t1 core_rdata", core_rdata, 32'hDEADBEEF);
        chk1("t1 dbg_rvalid", dbg_rvalid, 1'b0);

        // Debug masked write to 0x020 (holds 0x12345678), then core read
        step(); setDbg(1'b1, 1'b1, 12'h020, 4'b0011, 32'hA5A5A5A5);
        @(negedge clk); chk1("t3 dbg_gnt", dbg_gnt, 1'b1);
        step(); dbg_req = 1'b0; setCore(1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        @(negedge clk); chk1("t3 core_gnt", core_gnt, 1'b1);
        step(); core_req = 1'b0;
        @(negedge clk); chk("t3 masked rdata", core_rdata, 32'h1234A5A5);

        // Both ports continuously requesting: C C C C D repeating
        step(); newCore(100, 15); newDbg(100, 15);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cg = core_gnt;
            dg = dbg_gnt;
            chk1($sformatf("t2 core_gnt[%0d]", i), cg, (i % 5) != 4);
            chk1($sformatf("t2 dbg_gnt[%0d]", i), dg, (i % 5) == 4);
            step();
            if (cg) newCore(100, 15);
            if (dg) newDbg(100, 15);
        end
        core_req = 1'b0;
        dbg_req  = 1'b0;

        // Alternating write/read of 0x000..0x00F with no bubbles
        for (int k = 0; k < 16; k++) begin
            step(); setCore(1'b1, 1'b1, 12'(k), 4'hF, $urandom);
            @(negedge clk); chk1("t6 write gnt", core_gnt, 1'b1);
            step(); setCore(1'b1, 1'b0, 12'(k), 4'h0, 32'h0);
            @(negedge clk); chk1("t6 read gnt", core_gnt, 1'b1);
        end
        step(); core_req = 1'b0;

        // Halt handshake with a core read in flight
        arbChk = 1'b0;
        step(); setCore(1'b1, 1'b0, 12'h010, 4'h0, 32'h0); dbg_halt_req = 1'b1;
        @(negedge clk);
        chk1("t4 run core_gnt", core_gnt, 1'b1);
        chk1("t4 run ack", dbg_halt_ack, 1'b0);
        step(); setCore(1'b1, 1'b0, 12'h011, 4'h0, 32'h0); setDbg(1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        @(negedge clk);
        chk1("t4 drain core_gnt", core_gnt, 1'b0);
        chk1("t4 drain dbg_gnt", dbg_gnt, 1'b0);
        chk1("t4 drain ack", dbg_halt_ack, 1'b0);
        chk1("t4 drain core_rvalid", core_rvalid, 1'b1);
        chk("t4 drain core_rdata", core_rdata, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk1("t4 locked ack", dbg_halt_ack, 1'b1);
        chk1("t4 locked core_gnt", core_gnt, 1'b0);
        chk1("t4 locked dbg_gnt", dbg_gnt, 1'b1);
        step(); setDbg(1'b1, 1'b1, 12'h021, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        chk1("t4 locked2 ack", dbg_halt_ack, 1'b1);
        chk1("t4 locked2 core_gnt", core_gnt, 1'b0);
        chk1("t4 locked2 dbg_gnt", dbg_gnt, 1'b1);
        chk("t4 dbg_rdata", dbg_rdata, 32'h1234A5A5);
        step(); dbg_req = 1'b0; dbg_halt_req = 1'b0;
        @(negedge clk);
        chk1("t4 release ack", dbg_halt_ack, 1'b1);
        chk1("t4 release core_gnt", core_gnt, 1'b0);
        step();
        @(negedge clk);
        chk1("t4 after ack", dbg_halt_ack, 1'b0);
        chk1("t4 after core_gnt", core_gnt, 1'b1);
        step(); core_req = 1'b0;

        // Halt request withdrawn during DRAIN: back to RUN, no ack
        step(); dbg_halt_req = 1'b1;
        @(negedge clk); chk1("abort run ack", dbg_halt_ack, 1'b0);
        step(); dbg_halt_req = 1'b0; setCore(1'b1, 1'b0, 12'h005, 4'h0, 32'h0);
        @(negedge clk);
        chk1("abort drain core_gnt", core_gnt, 1'b0);
        chk1("abort drain ack", dbg_halt_ack, 1'b0);
        step();
        @(negedge clk);
        chk1("abort run core_gnt", core_gnt, 1'b1);
        chk1("abort run2 ack", dbg_halt_ack, 1'b0);
        step(); core_req = 1'b0;
        step();
        step(); arbChk = 1'b1;

        // Reset pulsed the cycle after a core read grant
        monEn = 1'b0;
        step(); setCore(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        @(negedge clk); chk1("t5 core_gnt", core_gnt, 1'b1);
        step(); rstn = 1'b0; core_req = 1'b0;
        @(negedge clk); chkAllIdle("t5 in reset");
        step(); rstn = 1'b1;
        @(negedge clk); chkAllIdle("t5 after reset");
        step(); setCore(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        @(negedge clk); chk1("t5 run core_gnt", core_gnt, 1'b1);
        step(); core_req = 1'b0;
        @(negedge clk);
        chk1("t5 core_rvalid", core_rvalid, 1'b1);
        chk("t5 core_rdata", core_rdata, 32'hDEADBEEF);
        step(); monEn = 1'b1; arbChk = 1'b1;

        // Randomised mixed traffic on both ports
        randCycles(400, 60, 50, 63);
        randCycles(100, 100, 100, 31);
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data SRAM between two requesters: the core load/store path (Excute/MemRd side) and a debug/loader port used for program load and memory inspection.
- Core has priority. A starvation counter guarantees the debug port progress.
- A halt handshake lets the debug port take exclusive ownership of the SRAM.
- Sits between the core memory interface and the data SRAM macro, clocked on the memory-phase clock.

Parameters:
- ADDR_W, 12, SRAM word-address width.
- DATA_W, 32, data width; byte mask width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive denied debug-request cycles before the debug port is forced to win (range 1..15).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- core_req  in  1  core access request, valid this cycle.
- core_we  in  1  1=write, 0=read.
- core_addr  in  ADDR_W  word address.
- core_wmask  in  DATA_W/8  byte write enables.
- core_wdata  in  DATA_W  write data.
- core_gnt  out  1  core access accepted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_W  core read data.
- dbg_req, dbg_we, dbg_addr, dbg_wmask, dbg_wdata  in  (same widths as core)  debug access request.
- dbg_gnt  out  1  debug access accepted this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_W  debug read data.
- dbg_halt_req  in  1  debug requests exclusive ownership.
- dbg_halt_ack  out  1  exclusive ownership held.
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wmask  out  DATA_W/8  SRAM byte mask.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read enable.

Behaviour:
Reset
- On rstn=0, asynchronously: state=RUN, starve_cnt=0, rd_owner pipeline cleared.
- All gnt, rvalid, halt_ack and mem_* outputs are 0. rdata outputs are 0.

Grants and SRAM drive
- Grants are combinational in the request cycle.
- The winner's addr/we/wmask/wdata drive mem_* combinationally, with mem_en = core_gnt | dbg_gnt.
- mem_we=0 whenever mem_en=0. At most one gnt is high per cycle.

Read data
- Read latency is 1 cycle. A registered rd_owner tag (NONE/CORE/DBG) is captured when a read is granted.
- Next cycle, the tagged port gets rvalid=1 and rdata=mem_rdata. The other port's rdata holds 0.
- Writes produce no rvalid. Back-to-back reads are supported every cycle.

State machine
- RUN:
  - Core wins if core_req=1, unless starve_cnt==STARVE_LIMIT and dbg_req=1, in which case debug wins.
  - Debug wins if core_req=0 and dbg_req=1.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each cycle with dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt=1 or dbg_req=0.
- RUN → DRAIN when dbg_halt_req=1.
- DRAIN:
  - No grants to either port.
  - Advances to LOCKED once there is no outstanding read (rd_owner==NONE in this cycle). This takes at most 1 cycle.
- LOCKED:
  - dbg_halt_ack=1 (registered, asserted on entry).
  - dbg_req is always granted; core_gnt=0 and core_req is ignored.
  - starve_cnt is held at 0.
- LOCKED → RUN when dbg_halt_req=0. halt_ack drops in the same edge, and the core may be granted the cycle after.
- dbg_halt_req dropping while in DRAIN returns to RUN with no ack pulse.

Boundary conditions
- Simultaneous core_req and dbg_req with starve_cnt < LIMIT: core is granted.
- STARVE_LIMIT reached while core_req is continuously high: exactly one debug grant, then the counter restarts.
- Reset mid-read: the pending rvalid is suppressed.
- Requesters must hold req, with stable fields, until gnt.

Test Plan:
1. Core read addr 0x010, SRAM holds 0xDEADBEEF → core_gnt same cycle, core_rvalid=1 with rdata=0xDEADBEEF exactly one cycle later; dbg_rvalid stays 0.
2. core_req and dbg_req both held high, STARVE_LIMIT=4 → grants CORE×4, DBG×1, CORE×4, DBG×1 …; never both high.
3. Debug write 0xA5A5A5A5 with wmask=4'b0011 to 0x020, then core read of 0x020 → core_rdata low half = 0xA5A5, upper half unchanged.
4. Core read granted, dbg_halt_req rises the same cycle → core_rvalid delivered next cycle; DRAIN 1 cycle; dbg_halt_ack=1; core_req then ignored until dbg_halt_req=0, and core granted 1 cycle after release.
5. rstn pulsed low the cycle after a core read grant → no core_rvalid, all outputs 0, state RUN after release.
6. Alternating core read/write to 0x000..0x00F every cycle → data integrity and correct rvalid per port with zero bubbles.
